lcd_bus_responder: RTL

- Synthesizable HD44780-compatible responder: the receiving end of the clock's 8-bit LCD write bus (rs/e/d).
- Synchronizes the bus, decodes each write on the falling edge of E, and maintains a DDRAM image, address counter (AC) and display flags.
- Emulates busy time and exposes a registered character read port, so the bench (or an on-board checker) can verify displayed time text.

---
 rtl/lcd_pkg.sv | 40 ++++
 rtl/lcd_ac_step.sv | 28 ++
 rtl/lcd_bus_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-compatible bus responder: instruction bit
// positions, the two-line DDRAM address map, FSM states and busy-time scaling.
package lcd_pkg;

  // Instruction class is given by the highest set bit of the data byte.
  localparam int BIT_SET_DDRAM = 7;
  localparam int BIT_SET_CGRAM = 6;
  localparam int BIT_FUNC      = 5;
  localparam int BIT_SHIFT     = 4;
  localparam int BIT_DISP      = 3;
  localparam int BIT_ENTRY     = 2;
  localparam int BIT_HOME      = 1;
  localparam int BIT_CLEAR     = 0;

  // Option bits inside the individual instructions.
  localparam int FUNC_DL  = 4;
  localparam int SHIFT_SC = 3;
  localparam int SHIFT_RL = 2;
  localparam int DISP_D   = 2;
  localparam int ENTRY_ID = 1;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE1_LAST = 7'h27;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE2_LAST = 7'h67;

  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  function automatic int unsigned us_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned us);
    return 32'((clk_hz * us) / 64'd1000000);
  endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Next address-counter value for one step in either direction, following the
// two-line DDRAM map (line 1 = 0x00-0x27, line 2 = 0x40-0x67).
module lcd_ac_step
  import lcd_pkg::*;
(
  input  logic [6:0] ac,
  input  logic       dir,
  output logic [6:0] ac_next
);

  logic in_map;

  always_comb begin
    in_map = (ac <= LINE1_LAST) || ((ac >= LINE2_BASE) && (ac <= LINE2_LAST));
    if (dir) begin
      if (ac == LINE1_LAST)      ac_next = LINE2_BASE;
      else if (ac == LINE2_LAST) ac_next = LINE1_BASE;
      else if (!in_map)          ac_next = LINE2_BASE;
      else                       ac_next = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE)      ac_next = LINE2_LAST;
      else if (ac == LINE2_BASE) ac_next = LINE1_LAST;
      else if (!in_map)          ac_next = LINE1_LAST;
      else                       ac_next = ac - 7'd1;
    end
  end

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible write-bus responder: synchronizes rs/e/d, decodes on E fall,
// keeps DDRAM/AC/flags and emulates busy time. Define BUSY_CHECK_EN for o_err checks.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int T_SHORT_US = 37,
  parameter int T_LONG_US  = 1520
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rs,
  input  logic       i_e,
  input  logic [7:0] i_d,
  input  logic [6:0] i_rd_addr,
  output logic [7:0] o_rd_char,
  output logic [6:0] o_ac,
  output logic       o_disp_on,
  output logic       o_init_done,
  output logic       o_wr_stb,
  output logic       o_busy,
  output logic       o_err,
  output logic [1:0] o_state
);

  localparam int unsigned SHORT_CYC = us_to_cycles(64'(CLK_HZ), 64'(T_SHORT_US));
  localparam int unsigned LONG_CYC  = us_to_cycles(64'(CLK_HZ), 64'(T_LONG_US));
  localparam int          TW        = $clog2(LONG_CYC + 1);
  localparam logic [TW-1:0] SHORT_LD = TW'(SHORT_CYC);
  localparam logic [TW-1:0] LONG_LD  = TW'(LONG_CYC);

  logic       e_s1, e_s2, rs_s1, rs_s2, fall;
  logic [7:0] d_s1, d_s2;
  logic       wr_vld, wr_rs;
  logic [7:0] wr_d;

  // Bus side is a 1-deep stream: wr_vld is a single-cycle valid with no ready;
  // the decoder must take it that cycle, or park it in the pending slot during CLEAR.
  assign fall = e_s2 & ~e_s1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      {e_s1, e_s2, rs_s1, rs_s2} <= '0;
      d_s1   <= '0;
      d_s2   <= '0;
      wr_vld <= 1'b0;
      wr_rs  <= 1'b0;
      wr_d   <= '0;
    end else begin
      e_s1   <= i_e;
      e_s2   <= e_s1;
      rs_s1  <= i_rs;
      rs_s2  <= rs_s1;
      d_s1   <= i_d;
      d_s2   <= d_s1;
      wr_vld <= fall;
      if (fall) begin
        wr_rs <= rs_s2;
        wr_d  <= d_s2;
      end
    end
  end

  state_t     state;
  logic [6:0] ac, clr_addr, ac_next, clr_next;
  logic       id, pend_vld, pend_rs;
  logic [7:0] pend_d;
  logic [TW-1:0] timer;
  logic       exe_vld, exe_rs, step_dir;
  logic [7:0] exe_d;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] ddram [0:127];

  // The write being executed comes from the bus in IDLE, from the pending slot in PEND.
  always_comb begin
    exe_vld = 1'b0;
    exe_rs  = wr_rs;
    exe_d   = wr_d;
    if (state == ST_IDLE) begin
      exe_vld = wr_vld;
    end else if (state == ST_PEND) begin
      exe_vld = pend_vld;
      exe_rs  = pend_rs;
      exe_d   = pend_d;
    end
  end

  assign step_dir = exe_rs ? id : exe_d[SHIFT_RL];

  lcd_ac_step u_ac_step  (.ac(ac),       .dir(step_dir), .ac_next(ac_next));
  lcd_ac_step u_clr_step (.ac(clr_addr), .dir(1'b1),     .ac_next(clr_next));

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = ac;
    mem_data = exe_d;
    if (state == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
      mem_data = SPACE;
    end else if (exe_vld && exe_rs) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      ac          <= '0;
      id          <= 1'b1;
      clr_addr    <= '0;
      pend_vld    <= 1'b0;
      pend_rs     <= 1'b0;
      pend_d      <= '0;
      timer       <= '0;
      o_disp_on   <= 1'b0;
      o_init_done <= 1'b0;
      o_wr_stb    <= 1'b0;
    end else begin
      o_wr_stb <= 1'b0;
      if (timer != '0) timer <= timer - 1'b1;
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_next;
          if (wr_vld && !pend_vld) begin
            pend_vld <= 1'b1;
            pend_rs  <= wr_rs;
            pend_d   <= wr_d;
          end
          if (clr_addr == LINE2_LAST) state <= (pend_vld || wr_vld) ? ST_PEND : ST_IDLE;
        end
        ST_PEND: begin
          // The slot is consumed this cycle, so a write landing now refills it.
          pend_vld <= wr_vld;
          pend_rs  <= wr_rs;
          pend_d   <= wr_d;
          state    <= wr_vld ? ST_PEND : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (exe_vld) begin
        if (exe_rs) begin
          o_wr_stb <= 1'b1;
          ac       <= ac_next;
          timer    <= SHORT_LD;
        end else if (exe_d[BIT_SET_DDRAM]) begin
          ac    <= exe_d[6:0];
          timer <= SHORT_LD;
        end else if (exe_d[BIT_SET_CGRAM]) begin
          timer <= SHORT_LD;
        end else if (exe_d[BIT_FUNC]) begin
          if (exe_d[FUNC_DL]) o_init_done <= 1'b1;
          timer <= SHORT_LD;
        end else if (exe_d[BIT_SHIFT]) begin
          if (!exe_d[SHIFT_SC]) ac <= ac_next;
          timer <= SHORT_LD;
        end else if (exe_d[BIT_DISP]) begin
          o_disp_on <= exe_d[DISP_D];
          timer     <= SHORT_LD;
        end else if (exe_d[BIT_ENTRY]) begin
          id    <= exe_d[ENTRY_ID];
          timer <= SHORT_LD;
        end else if (exe_d[BIT_HOME]) begin
          ac    <= '0;
          timer <= LONG_LD;
        end else if (exe_d[BIT_CLEAR]) begin
          ac       <= '0;
          id       <= 1'b1;
          timer    <= LONG_LD;
          clr_addr <= LINE1_BASE;
          state    <= ST_CLEAR;
        end
      end
    end
  end

  // DDRAM content deliberately survives reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) ddram[mem_addr] <= mem_data;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_rd_char <= '0;
    else         o_rd_char <= ddram[i_rd_addr];
  end

  assign o_ac    = ac;
  assign o_busy  = (timer != '0);
  assign o_state = state;

`ifdef BUSY_CHECK_EN
  logic [1:0] e_hi_cnt;
  logic       err;

  // e_hi_cnt counts earlier high cycles, so the fall cycle itself makes the total cnt+1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      e_hi_cnt <= '0;
      err      <= 1'b0;
    end else begin
      e_hi_cnt <= e_s2 ? ((e_hi_cnt == 2'd3) ? 2'd3 : e_hi_cnt + 2'd1) : 2'd0;
      if ((fall && (o_busy || (e_hi_cnt < 2'd2))) ||
          ((state == ST_CLEAR) && wr_vld && pend_vld))
        err <= 1'b1;
    end
  end

  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif

endmodule
